axi_stride_read_initiator: RTL
==============================

// Module: axi_stride_read_initiator
// PURPOSE
//  AXI read-channel initiator (AR out, R in) for the prefetcher slave port (s_ar/s_r) or axi_ram.
//  Issues NUM_REQ strided bursts from a latched config, consumes and checks R beats, and reports completion and errors.
//  Replaces hand-driven AR/R stimulus in system benches. Also usable as a synthesizable traffic generator.
// PARAMETERS
//  ADDR_BITS        16  AR address width
//  BURST_LEN_WIDTH  8   AR len width (beats = len+1)
//  TID_WIDTH        8   AR/R id width
//  DATA_WIDTH       8   R data width (power of 2, >=8)
//  REQ_CNT_WIDTH    8   width of request and beat counters
//  MAX_OUTSTANDING  4   maximum bursts issued but not yet completed (>=1)
// PORTS
//  clk           in   1                clock, rising edge
//  rst           in   1                async active-high reset
//  start         in   1                1-cycle pulse that latches config; ignored while busy=1
//  base_addr     in   ADDR_BITS        first burst address
//  stride        in   ADDR_BITS        address increment between bursts
//  num_req       in   REQ_CNT_WIDTH    number of bursts to issue
//  burst_len     in   BURST_LEN_WIDTH  AXI len driven on every burst
//  txn_id        in   TID_WIDTH        AR id; also the expected R id
//  m_ar_valid    out  1                AR valid
//  m_ar_ready    in   1                AR ready
//  m_ar_addr     out  ADDR_BITS        AR address
//  m_ar_len      out  BURST_LEN_WIDTH  AR len
//  m_ar_id       out  TID_WIDTH        AR id
//  m_r_valid     in   1                R valid
//  m_r_ready     out  1                R ready
//  m_r_data      in   DATA_WIDTH       R data
//  m_r_last      in   1                R last
//  m_r_id        in   TID_WIDTH        R id
//  busy          out  1                run in progress
//  done          out  1                1-cycle completion pulse
//  beat_cnt      out  REQ_CNT_WIDTH    R beats accepted this run (wraps)
//  errorCode     out  3                sticky: [0] id mismatch, [1] last misplaced, [2] unexpected beat
//  data_err_cnt  out  REQ_CNT_WIDTH    data mismatches (see CONFIGURATION)
// BEHAVIOUR
//  Reset: state IDLE. All outputs 0. All counters 0.
//  FSM states:
//   IDLE->ISSUE on start with num_req!=0. IDLE->DONE on start with num_req==0.
//   ISSUE->DRAIN on the AR handshake of the last burst.
//   DRAIN->DONE when outstanding==0.
//   DONE->IDLE unconditionally after 1 cycle; done=1 only in DONE.
//  On start: latch all config. Clear errorCode, beat_cnt and data_err_cnt. No AR in the start cycle; first m_ar_valid the next cycle.
//  AR addr(i) = base_addr + i*stride, modulo 2^ADDR_BITS (silent wrap). m_ar_len=burst_len, m_ar_id=txn_id.
//  m_ar_valid=1 in ISSUE while outstanding<MAX_OUTSTANDING. Once asserted, it stays high with addr/len/id stable until m_ar_ready.
//  After a handshake the next burst may be presented in the following cycle (1 AR/cycle maximum).
//  m_r_ready = busy (ISSUE or DRAIN); 0 in IDLE/DONE.
//  A beat is accepted on m_r_valid&m_r_ready. beat_cnt++ per beat. Beat index within the burst counted 0..burst_len.
//  outstanding: +1 on AR handshake; -1 on accepted beat with m_r_last; both in the same cycle -> unchanged.
//  Checks per accepted beat:
//   m_r_id!=txn_id -> errorCode[0].
//   m_r_last!=(beat index==burst_len) -> errorCode[1]. The burst still closes on m_r_last as received.
//   beat accepted with outstanding==0 -> errorCode[2]; beat otherwise ignored, outstanding held at 0.
//  R assumed in order (single id). A response-side burst index tracks which burst each beat belongs to.
//  busy=1 in ISSUE/DRAIN. start during busy or DONE is ignored.
//  rst mid-run: immediate return to IDLE. m_ar_valid drops even without a handshake (accepted AXI violation; bench resets the slave too).
// CONFIGURATION
//  STRIDE_READER_DATA_CHECK_EN defined:
//   beat k of burst i expects m_r_data == low DATA_WIDTH bits of ((addr(i)-base_addr)/(DATA_WIDTH/8) + k).
//   This is the ramp image written at base_addr.
//   Each mismatch increments data_err_cnt, saturating at all-ones.
//  Undefined: no compare logic; data_err_cnt tied to 0.
// TESTING  (axi_ram slave, ramp 0..99 written at 0x0eef, DATA_WIDTH=8)
//  T1 base=0x0eef stride=3 num_req=3 len=0 id=5
//     -> AR addrs 0x0eef,0x0ef2,0x0ef5; 3 beats; beat_cnt=3; done 1 pulse; errorCode=000
//     -> with _EN, data 0,3,6 and data_err_cnt=0.
//  T2 m_ar_ready held 0 for 5 cycles after first valid
//     -> m_ar_valid stays 1; addr stays 0x0eef; handshake on the 6th cycle.
//  T3 MAX_OUTSTANDING=4, num_req=6, R held off
//     -> exactly 4 AR handshakes; 5th AR valid only after the first R last.
//  T4 base=0xFFFE stride=2 num_req=2 -> AR addrs 0xFFFE, 0x0000.
//  T5 stub returns id 6, then len=1 burst with last on beat 0
//     -> errorCode=011; done still asserted after drain.
//  T6 num_req=0 -> done 1 cycle after start, no AR.
//     rst during ISSUE -> next cycle m_ar_valid=0, busy=0, beat_cnt=0.

Source files
------------

// File: rtl/axi_stride_read_if.sv
// AR/R channel bundle between the stride read initiator and an AXI read slave.
interface axi_stride_read_if #(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8
);
    logic                       m_ar_valid;
    logic                       m_ar_ready;
    logic [ADDR_BITS-1:0]       m_ar_addr;
    logic [BURST_LEN_WIDTH-1:0] m_ar_len;
    logic [TID_WIDTH-1:0]       m_ar_id;
    logic                       m_r_valid;
    logic                       m_r_ready;
    logic [DATA_WIDTH-1:0]      m_r_data;
    logic                       m_r_last;
    logic [TID_WIDTH-1:0]       m_r_id;

    modport master (
        output m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        input  m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );

    modport slave (
        input  m_ar_valid, m_ar_addr, m_ar_len, m_ar_id, m_r_ready,
        output m_ar_ready, m_r_valid, m_r_data, m_r_last, m_r_id
    );
endinterface

// File: rtl/axi_stride_read_initiator.sv
// Strided AXI read burst generator with R-beat checking and completion report.
// Optional ramp data compare enabled by STRIDE_READER_DATA_CHECK_EN.
module axi_stride_read_initiator #(
    parameter int ADDR_BITS       = 16,
    parameter int BURST_LEN_WIDTH = 8,
    parameter int TID_WIDTH       = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int REQ_CNT_WIDTH   = 8,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [ADDR_BITS-1:0]       base_addr,
    input  logic [ADDR_BITS-1:0]       stride,
    input  logic [REQ_CNT_WIDTH-1:0]   num_req,
    input  logic [BURST_LEN_WIDTH-1:0] burst_len,
    input  logic [TID_WIDTH-1:0]       txn_id,
    axi_stride_read_if.master          m,
    output logic                       busy,
    output logic                       done,
    output logic [REQ_CNT_WIDTH-1:0]   beat_cnt,
    output logic [2:0]                 errorCode,
    output logic [REQ_CNT_WIDTH-1:0]   data_err_cnt
);
    localparam int OUT_W = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

    state_t                     state, state_n;
    logic [ADDR_BITS-1:0]       cfg_stride;
    logic [REQ_CNT_WIDTH-1:0]   cfg_num;
    logic [BURST_LEN_WIDTH-1:0] cfg_len;
    logic [TID_WIDTH-1:0]       cfg_id;
    logic [ADDR_BITS-1:0]       ar_addr;
    logic [REQ_CNT_WIDTH-1:0]   ar_cnt;
    logic [OUT_W-1:0]           outstanding;
    logic [BURST_LEN_WIDTH-1:0] beat_idx;
    logic                       ar_valid;
    logic                       ar_hs;
    logic                       r_hs;
    logic                       beat_ok;
    logic                       last_ar;

    assign m.m_ar_valid = ar_valid;
    assign m.m_ar_addr  = ar_addr;
    assign m.m_ar_len   = cfg_len;
    assign m.m_ar_id    = cfg_id;
    assign m.m_r_ready  = busy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n  = state;
        busy     = 1'b0;
        done     = 1'b0;
        ar_valid = 1'b0;
        busy     = (state == S_ISSUE) || (state == S_DRAIN);
        done     = (state == S_DONE);
        ar_valid = (state == S_ISSUE) &&
                   (outstanding < OUT_W'(MAX_OUTSTANDING));
        last_ar  = (ar_cnt == cfg_num - 1'b1);
        ar_hs    = ar_valid && m.m_ar_ready;
        r_hs     = busy && m.m_r_valid;
        beat_ok  = r_hs && (outstanding != '0);
        unique case (state)
            S_IDLE:  if (start) state_n = (num_req != '0) ? S_ISSUE : S_DONE;
            S_ISSUE: if (ar_hs && last_ar) state_n = S_DRAIN;
            S_DRAIN: if (outstanding == '0) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg_stride  <= '0;
            cfg_num     <= '0;
            cfg_len     <= '0;
            cfg_id      <= '0;
            ar_addr     <= '0;
            ar_cnt      <= '0;
            outstanding <= '0;
            beat_idx    <= '0;
            beat_cnt    <= '0;
            errorCode   <= '0;
        end else if (state == S_IDLE && start) begin
            cfg_stride  <= stride;
            cfg_num     <= num_req;
            cfg_len     <= burst_len;
            cfg_id      <= txn_id;
            ar_addr     <= base_addr;
            ar_cnt      <= '0;
            outstanding <= '0;
            beat_idx    <= '0;
            beat_cnt    <= '0;
            errorCode   <= '0;
        end else begin
            if (ar_hs) begin
                ar_addr <= ar_addr + cfg_stride;
                ar_cnt  <= ar_cnt + 1'b1;
            end
            if (r_hs && !beat_ok) errorCode[2] <= 1'b1;
            if (beat_ok) begin
                beat_cnt <= beat_cnt + 1'b1;
                if (m.m_r_id != cfg_id) errorCode[0] <= 1'b1;
                if (m.m_r_last != (beat_idx == cfg_len)) errorCode[1] <= 1'b1;
                beat_idx <= m.m_r_last ? '0 : beat_idx + 1'b1;
            end
            // Simultaneous issue and burst close leave the count unchanged
            unique case ({ar_hs, beat_ok && m.m_r_last})
                2'b10:   outstanding <= outstanding + 1'b1;
                2'b01:   outstanding <= outstanding - 1'b1;
                default: outstanding <= outstanding;
            endcase
        end
    end

`ifdef STRIDE_READER_DATA_CHECK_EN
    localparam int SHIFT = $clog2(DATA_WIDTH / 8);

    // Offset of the current response burst from base_addr
    logic [ADDR_BITS-1:0]  rsp_off;
    logic [ADDR_BITS-1:0]  exp_word;
    logic [DATA_WIDTH-1:0] exp_data;

    assign exp_word = (rsp_off >> SHIFT) + ADDR_BITS'(beat_idx);
    assign exp_data = DATA_WIDTH'(exp_word);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_off      <= '0;
            data_err_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            rsp_off      <= '0;
            data_err_cnt <= '0;
        end else if (beat_ok) begin
            if (m.m_r_last) rsp_off <= rsp_off + cfg_stride;
            if (m.m_r_data != exp_data && data_err_cnt != '1)
                data_err_cnt <= data_err_cnt + 1'b1;
        end
    end
`else
    assign data_err_cnt = '0;
`endif
endmodule
